// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - serial frame capture FSM with valid/ready word output
//
// Hunts for a start marker (serial_in=1), shifts WIDTH data bits MSB-first,
// checks the stop bit (must be 0) and presents the word on a valid/ready port.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   en          bit strobe; frame FSM advances only when en=1
//   serial_in   serial line (idle=0, start=1, data MSB-first, stop=0)
//   data_out    captured word, first data bit in MSB
//   out_valid   data_out holds an unconsumed word
//   out_ready   consumer accepts data_out when out_valid=1
//   busy        FSM not in IDLE
//   frame_err   one-cycle pulse on a bad stop bit (frame discarded)
//   overrun     sticky; a good frame was dropped while out_valid=1
//   clr_ovr     clears overrun (a same-edge set wins)
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STOP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (clr_ovr) ovr_d = 1'b0;

    // Handshake runs every cycle regardless of en; a load below overrides it.
    if (valid_q && out_ready) valid_d = 1'b0;

    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (serial_in) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        S_SHIFT: begin
          shreg_d = {shreg_q[WIDTH-2:0], serial_in};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_STOP;
            cnt_d   = '0;
          end
        end
        S_STOP: begin
          state_d = S_IDLE;
          shreg_d = '0;
          if (!serial_in) begin
            // Slot is free if empty or being consumed on this very edge.
            if (!valid_q || out_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - directed self-checking bench for sipo_frame_ctrl
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       serial_in;
  logic [3:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       clr_ovr;

  int checks   = 0;
  int failures = 0;

  sipo_frame_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .serial_in (serial_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    tick();
  endtask

  // Start, 4 data bits MSB-first, stop.
  task automatic send_frame(input logic [3:0] w, input logic stop);
    send_bit(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    send_bit(stop);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(data_out),  32'h0);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_busy"},  32'(busy),      32'h0);
    check({tag, "_ferr"},  32'(frame_err), 32'h0);
    check({tag, "_ovr"},   32'(overrun),   32'h0);
  endtask

  initial begin
    logic [5:0] t1_bits;
    rst = 1'b1; en = 1'b1; serial_in = 1'b0; out_ready = 1'b1; clr_ovr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Test 1: good frame 1011, bit-by-bit busy tracking.
    t1_bits = 6'b110110;
    for (int i = 5; i >= 1; i--) begin
      send_bit(t1_bits[i]);
      check($sformatf("t1_busy_e%0d", 6 - i), 32'(busy), 32'h1);
      check($sformatf("t1_valid_e%0d", 6 - i), 32'(out_valid), 32'h0);
    end
    send_bit(t1_bits[0]);
    check("t1_data",  32'(data_out),  32'hB);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_busy",  32'(busy),      32'h0);
    send_bit(1'b0);
    check("t1_consumed", 32'(out_valid), 32'h0);
    check("t1_hold",     32'(data_out),  32'hB);

    // Test 2: bad stop bit.
    send_frame(4'b0110, 1'b1);
    check("t2_ferr",  32'(frame_err), 32'h1);
    check("t2_valid", 32'(out_valid), 32'h0);
    check("t2_busy",  32'(busy),      32'h0);
    send_bit(1'b0);
    check("t2_ferr_pulse", 32'(frame_err), 32'h0);
    check("t2_data_kept",  32'(data_out),  32'hB);

    // Test 3: overrun, with a clear on the same edge as the set (set wins).
    out_ready = 1'b0;
    send_frame(4'b1011, 1'b0);
    check("t3_valid1", 32'(out_valid), 32'h1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    clr_ovr = 1'b1;
    send_bit(1'b0);
    clr_ovr = 1'b0;
    check("t3_data_kept", 32'(data_out),  32'hB);
    check("t3_ovr",       32'(overrun),   32'h1);
    check("t3_valid2",    32'(out_valid), 32'h1);
    clr_ovr = 1'b1;
    send_bit(1'b0);
    clr_ovr = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'h0);

    // Test 4: consume on the same edge that loads the next word.
    send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    out_ready = 1'b1;
    send_bit(1'b0);
    check("t4_data",  32'(data_out),  32'h6);
    check("t4_valid", 32'(out_valid), 32'h1);
    check("t4_ovr",   32'(overrun),   32'h0);
    send_bit(1'b0);
    check("t4_consumed", 32'(out_valid), 32'h0);

    // Test 5: 3-cycle en stall between data bits 2 and 3.
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      check($sformatf("t5_stall_busy%0d", i), 32'(busy), 32'h1);
    end
    en = 1'b1;
    send_bit(1'b1); send_bit(1'b1);
    check("t5_pre_stop_valid", 32'(out_valid), 32'h0);
    send_bit(1'b0);
    check("t5_data",  32'(data_out),  32'hB);
    check("t5_valid", 32'(out_valid), 32'h1);
    check("t5_busy",  32'(busy),      32'h0);
    send_bit(1'b0);

    // Test 6: reset mid-frame, then a clean frame 0101.
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    send_bit(1'b1);
    rst = 1'b0;
    check_all_zero("t6_rst");
    send_frame(4'b0101, 1'b0);
    check("t6_data",  32'(data_out),  32'h5);
    check("t6_valid", 32'(out_valid), 32'h1);
    check("t6_ferr",  32'(frame_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
